// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: tracks in-flight register writes in a shift-register
// scoreboard and drives stallb_en (1 = advance, 0 = freeze) for the stall
// clock gating unit. Fetch freezes on a RAW hazard, for the length of a
// multi-cycle op, and while an external stall request is pending.
module hazard_stall_ctrl #(
  parameter int REG_AW     = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int MC_CYCLES  = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic              rs1_used,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic              rs2_used,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              rd_we,
  input  logic              mc_op,
  input  logic              ext_stall_req,
  output logic              stallb_en,
  output logic              hazard,
  output logic [7:0]        stall_cnt,
  output logic [1:0]        state
);

  localparam int CW = $clog2(MC_CYCLES) + 1;
  localparam logic [CW-1:0] MC_LOAD = CW'(MC_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_HAZ = 2'd1,
    ST_MC  = 2'd2,
    ST_EXT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       mc_cnt_q, mc_cnt_d;
  logic [7:0]          stall_cnt_q, stall_cnt_d;
  logic [PIPE_DEPTH-1:0] sb_v_q, sb_v_d;
  logic [REG_AW-1:0]   sb_addr_q [PIPE_DEPTH];
  logic [REG_AW-1:0]   sb_addr_d [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] hit1, hit2;
  logic                haz;
  logic                stall_en;
  logic                issue;

  // Per-slot address compare; an entry blocks readers until it shifts out.
  for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_match
    assign hit1[gi] = sb_v_q[gi] && (sb_addr_q[gi] == rs1_addr);
    assign hit2[gi] = sb_v_q[gi] && (sb_addr_q[gi] == rs2_addr);
  end

  // r0 never creates a dependency.
  assign haz = (rs1_used && (rs1_addr != '0) && (|hit1)) ||
               (rs2_used && (rs2_addr != '0) && (|hit2));

  // Slot 0 takes the issuing write (or a bubble); older slots shift down.
  assign sb_v_d[0]    = issue && rd_we && (rd_addr != '0);
  assign sb_addr_d[0] = rd_addr;
  for (genvar gi = 1; gi < PIPE_DEPTH; gi++) begin : g_shift
    assign sb_v_d[gi]    = sb_v_q[gi-1];
    assign sb_addr_d[gi] = sb_addr_q[gi-1];
  end

  // Advance enable from registered state plus current decode inputs.
  always_comb begin
    stall_en = 1'b0;
    if (rst) begin
      case (state_q)
        ST_RUN:  stall_en = !ext_stall_req && !(instr_valid && haz);
        ST_HAZ:  stall_en = !haz;
        default: stall_en = 1'b0;
      endcase
    end
  end

  assign issue = instr_valid && stall_en;

  // Next-state logic; external stall beats hazard, hazard beats multi-cycle.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ext_stall_req) begin
          state_d = ST_EXT;
        end else if (instr_valid && haz) begin
          state_d = ST_HAZ;
        end else if (issue && mc_op) begin
          state_d  = ST_MC;
          mc_cnt_d = MC_LOAD;
        end
      end
      ST_HAZ: begin
        if (!haz) begin
          if (issue && mc_op) begin
            state_d  = ST_MC;
            mc_cnt_d = MC_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_MC: begin
        mc_cnt_d = mc_cnt_q - CW'(1);
        if (mc_cnt_q == CW'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (!ext_stall_req) begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // Saturating count of frozen cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!stall_en && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  // Control state registers; reset abandons any stall in progress.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Scoreboard shift register, cleared on reset.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      sb_v_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
      end
    end else begin
      sb_v_q <= sb_v_d;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sb_addr_q[i] <= sb_addr_d[i];
      end
    end
  end

  assign stallb_en = stall_en;
  assign hazard    = rst && (state_q == ST_HAZ);
  assign stall_cnt = stall_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios followed by random decode
// traffic, every cycle compared against a behavioural model that tracks the
// cycle of the last write to each register and the cycle an MC op ends.
module tb_hazard_stall_ctrl;
  localparam int REG_AW     = 4;
  localparam int PIPE_DEPTH = 3;
  localparam int MC_CYCLES  = 4;
  localparam int NREGS      = 1 << REG_AW;

  logic              clk_in = 1'b0;
  logic              rst = 1'b0;
  logic              instr_valid = 1'b0;
  logic [REG_AW-1:0] rs1_addr = '0;
  logic              rs1_used = 1'b0;
  logic [REG_AW-1:0] rs2_addr = '0;
  logic              rs2_used = 1'b0;
  logic [REG_AW-1:0] rd_addr = '0;
  logic              rd_we = 1'b0;
  logic              mc_op = 1'b0;
  logic              ext_stall_req = 1'b0;
  wire               stallb_en;
  wire               hazard;
  wire  [7:0]        stall_cnt;
  wire  [1:0]        state;

  always #5 clk_in = ~clk_in;

  hazard_stall_ctrl #(
    .REG_AW(REG_AW), .PIPE_DEPTH(PIPE_DEPTH), .MC_CYCLES(MC_CYCLES)
  ) dut (
    .clk_in(clk_in), .rst(rst), .instr_valid(instr_valid),
    .rs1_addr(rs1_addr), .rs1_used(rs1_used),
    .rs2_addr(rs2_addr), .rs2_used(rs2_used),
    .rd_addr(rd_addr), .rd_we(rd_we), .mc_op(mc_op),
    .ext_stall_req(ext_stall_req),
    .stallb_en(stallb_en), .hazard(hazard),
    .stall_cnt(stall_cnt), .state(state)
  );

  int checks = 0;
  int failures = 0;

  // Model: mode 0=RUN 1=HAZ 2=MC 3=EXT, write history per register.
  int cyc = 0;
  int last_wr [NREGS];
  int m_mode = 0;
  int m_mc_end = 0;
  int m_cnt = 0;
  bit m_last_issue = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_history();
    for (int r = 0; r < NREGS; r++) last_wr[r] = -1000;
  endtask

  // A register is blocked for PIPE_DEPTH cycles after the cycle its writer issued.
  function automatic bit m_blocked(input int r);
    return (r != 0) && ((cyc - last_wr[r]) <= PIPE_DEPTH);
  endfunction

  function automatic bit m_haz();
    return (rs1_used && m_blocked(int'(rs1_addr))) || (rs2_used && m_blocked(int'(rs2_addr)));
  endfunction

  task automatic drive_instr(input bit iv, input int s1, input bit u1, input int s2,
                             input bit u2, input int rd, input bit we, input bit mc);
    instr_valid = iv;
    rs1_addr = REG_AW'(s1); rs1_used = u1;
    rs2_addr = REG_AW'(s2); rs2_used = u2;
    rd_addr = REG_AW'(rd); rd_we = we; mc_op = mc;
  endtask

  task automatic cycles(input int n);
    bit h, exp_sb, iss;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      h = m_haz();
      exp_sb = 1'b0;
      if (rst) begin
        case (m_mode)
          0: exp_sb = !ext_stall_req && !(instr_valid && h);
          1: exp_sb = !h;
          default: exp_sb = 1'b0;
        endcase
      end
      check_val("stallb_en", 32'(stallb_en), 32'(exp_sb));
      check_val("hazard", 32'(hazard), 32'(rst && (m_mode == 1)));
      check_val("state", 32'(state), 32'(m_mode));
      check_val("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      iss = instr_valid && exp_sb;
      if (!rst) begin
        m_mode = 0;
        m_cnt = 0;
        clear_history();
      end else begin
        if (!exp_sb && m_cnt < 255) m_cnt++;
        if (iss && rd_we) last_wr[int'(rd_addr)] = cyc;
        case (m_mode)
          0: begin
            if (ext_stall_req) m_mode = 3;
            else if (instr_valid && h) m_mode = 1;
            else if (iss && mc_op) begin m_mode = 2; m_mc_end = cyc + MC_CYCLES - 1; end
          end
          1: begin
            if (!h) begin
              if (iss && mc_op) begin m_mode = 2; m_mc_end = cyc + MC_CYCLES - 1; end
              else m_mode = 0;
            end
          end
          2: if (cyc == m_mc_end) m_mode = 0;
          default: if (!ext_stall_req) m_mode = 0;
        endcase
      end
      m_last_issue = iss;
      cyc++;
      @(posedge clk_in);
      #1;
    end
  endtask

  initial begin
    clear_history();
    @(posedge clk_in);
    #1;
    // Reset held, then released with no instruction
    cycles(2);
    rst = 1'b1;
    cycles(1);
    // RAW on r3
    drive_instr(1, 0, 0, 0, 0, 3, 1, 0); cycles(1);
    drive_instr(1, 3, 1, 0, 0, 0, 0, 0); cycles(4);
    drive_instr(0, 0, 0, 0, 0, 0, 0, 0); cycles(1);
    // Writes to r0 never block
    drive_instr(1, 0, 0, 0, 0, 0, 1, 0); cycles(1);
    drive_instr(1, 0, 1, 0, 1, 0, 0, 0); cycles(2);
    // Multi-cycle op
    drive_instr(1, 0, 0, 0, 0, 7, 0, 1); cycles(1);
    drive_instr(0, 0, 0, 0, 0, 0, 0, 0); cycles(4);
    // External stall overlapping a pending RAW on r2
    drive_instr(1, 0, 0, 0, 0, 2, 1, 0); cycles(1);
    drive_instr(1, 2, 1, 0, 0, 0, 0, 0); ext_stall_req = 1'b1; cycles(5);
    ext_stall_req = 1'b0; cycles(5);
    // Reset in the middle of an MC op, dependent read afterwards
    drive_instr(1, 0, 0, 0, 0, 5, 1, 1); cycles(1);
    drive_instr(0, 0, 0, 0, 0, 0, 0, 0); cycles(1);
    rst = 1'b0; cycles(1);
    rst = 1'b1;
    drive_instr(1, 5, 1, 0, 0, 0, 0, 0); cycles(2);
    // Long external stall saturates the counter
    drive_instr(0, 0, 0, 0, 0, 0, 0, 0); ext_stall_req = 1'b1; cycles(300);
    ext_stall_req = 1'b0; cycles(3);
    rst = 1'b0; cycles(1);
    rst = 1'b1;
    // Random traffic; a stalled instruction is held by the frozen upstream
    for (int n = 0; n < 3000; n++) begin
      if (m_last_issue || !instr_valid) begin
        drive_instr(($urandom % 4) != 0,
                    int'($urandom_range(0, ($urandom % 4 == 0) ? NREGS - 1 : 3)), $urandom % 2,
                    int'($urandom_range(0, 3)), $urandom % 2,
                    int'($urandom_range(0, 3)), ($urandom % 3) != 0,
                    ($urandom % 6) == 0);
      end
      ext_stall_req = ($urandom % 10) == 0;
      rst = ($urandom % 150) != 0;
      cycles(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
